// File: rtl/opb_register_ppc2simulink.sv
// OPB slave holding one 32-bit control register that the PPC writes (byte-enabled) and reads back.
// The current value drives user logic continuously; user_data_wr pulses once per accepted write.
module opb_register_ppc2simulink #(
   parameter logic [31:0] C_BASEADDR    = 32'h01008200,
   parameter logic [31:0] C_HIGHADDR    = 32'h010082FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter              C_FAMILY      = "virtex5",
   parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_RNW,
   input  logic                        OPB_select,
   input  logic                        OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
   output logic                        Sl_xferAck,
   output logic                        Sl_errAck,
   output logic                        Sl_retry,
   output logic                        Sl_toutSup,
   output logic [C_OPB_DWIDTH-1:0]     user_data_out,
   output logic                        user_data_wr
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACK  = 1'b1;

   localparam int unused_family_bits = $bits(C_FAMILY);

   logic                    unused_inputs;
   logic [0:0]              state;
   logic                    hit;
   logic                    req;
   logic [C_OPB_DWIDTH-1:0] wr_data;

   assign unused_inputs = OPB_seqAddr;

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   assign hit = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign req = (state == IDLE) && OPB_select && hit;

   // OPB bit i is user bit DWIDTH-1-i, so byte lane k lands on the k-th byte from the top.
   always_comb begin
      wr_data = user_data_out;
      for (int k = 0; k < C_OPB_DWIDTH / 8; k++) begin
         if (OPB_BE[k]) begin
            wr_data[C_OPB_DWIDTH-1-8*k -: 8] = OPB_DBus[8*k +: 8];
         end
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state         <= IDLE;
         Sl_xferAck    <= 1'b0;
         Sl_DBus       <= '0;
         user_data_wr  <= 1'b0;
         user_data_out <= C_RESET_VALUE[C_OPB_DWIDTH-1:0];
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state        <= ACK;
                  Sl_xferAck   <= 1'b1;
                  user_data_wr <= ~OPB_RNW;
                  Sl_DBus      <= OPB_RNW ? user_data_out : '0;
                  if (!OPB_RNW) begin
                     user_data_out <= wr_data;
                  end
               end else begin
                  Sl_xferAck   <= 1'b0;
                  user_data_wr <= 1'b0;
                  Sl_DBus      <= '0;
               end
            end
            default: begin
               // A select still high here belongs to the next transfer; IDLE samples it next edge.
               state        <= IDLE;
               Sl_xferAck   <= 1'b0;
               user_data_wr <= 1'b0;
               Sl_DBus      <= '0;
            end
         endcase
      end
   end

endmodule
